// File: rtl/bram_stream_loader.sv
// Byte-stream to BRAM0 word loader that kicks a downstream accessor when done.
// Optional LOADER_EARLY_LAST_EN: s_last_i ends the load early with zero padding.
module bram_stream_loader #(
  parameter int CNT_BIT       = 31,
  parameter int DWIDTH        = 32,
  parameter int AWIDTH        = 8,
  parameter int MEM_SIZE      = 256,
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_load_i,
  input  logic [CNT_BIT-1:0]       load_count_i,
  input  logic                     s_valid_i,
  input  logic [IN_DATA_WIDTH-1:0] s_data_i,
  input  logic                     s_last_i,
  output logic                     s_ready_o,
  output logic [AWIDTH-1:0]        addr_b0_o,
  output logic                     ce_b0_o,
  output logic                     we_b0_o,
  output logic [DWIDTH-1:0]        d_b0_o,
  output logic                     start_run_o,
  output logic [CNT_BIT-1:0]       run_count_o,
  input  logic                     acc_done_i,
  output logic                     idle_o,
  output logic                     load_o,
  output logic                     done_o
);

  localparam int NB = DWIDTH / IN_DATA_WIDTH;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_BIT-1:0] MAX_CNT = CNT_BIT'(MEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [CNT_BIT-1:0] word_q, word_d;
  logic [CNT_BIT-1:0] run_cnt_q, run_cnt_d;
  logic [BW-1:0]      byte_q, byte_d;
  logic [DWIDTH-1:0]  pack_q, pack_d;
  logic [DWIDTH-1:0]  data_q, data_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic               wr_q, wr_d;

  logic              early_last;
  logic              flush;
  logic [DWIDTH-1:0] packed_w;

`ifdef LOADER_EARLY_LAST_EN
  assign early_last = s_last_i;
`else
  logic unused_last;
  assign unused_last = s_last_i;
  assign early_last  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    run_cnt_d = run_cnt_q;
    byte_d    = byte_q;
    pack_d    = pack_q;
    data_d    = data_q;
    addr_d    = addr_q;
    wr_d      = 1'b0;
    packed_w  = pack_q;
    packed_w[IN_DATA_WIDTH*byte_q +: IN_DATA_WIDTH] = s_data_i;
    flush     = (byte_q == BW'(NB-1)) || early_last;
    unique case (state_q)
      S_IDLE: begin
        if (start_load_i) begin
          cnt_d   = (load_count_i > MAX_CNT) ? MAX_CNT : load_count_i;
          word_d  = '0;
          byte_d  = '0;
          pack_d  = '0;
          state_d = (load_count_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (s_valid_i) begin
          if (flush) begin
            // Word complete (or cut short): register the BRAM write for next cycle
            wr_d   = 1'b1;
            addr_d = word_q[AWIDTH-1:0];
            data_d = packed_w;
            pack_d = '0;
            byte_d = '0;
            word_d = word_q + CNT_BIT'(1);
            if ((word_d == cnt_q) || early_last) begin
              run_cnt_d = word_d;
              state_d   = S_KICK;
            end
          end else begin
            pack_d = packed_w;
            byte_d = byte_q + BW'(1);
          end
        end
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: if (acc_done_i) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      run_cnt_q <= '0;
      byte_q    <= '0;
      pack_q    <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      run_cnt_q <= run_cnt_d;
      byte_q    <= byte_d;
      pack_q    <= pack_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
    end
  end

  assign idle_o      = (state_q == S_IDLE);
  assign load_o      = (state_q == S_LOAD);
  assign s_ready_o   = (state_q == S_LOAD);
  assign start_run_o = (state_q == S_KICK);
  assign done_o      = (state_q == S_DONE);
  assign run_count_o = run_cnt_q;
  assign ce_b0_o     = wr_q;
  assign we_b0_o     = wr_q;
  assign addr_b0_o   = addr_q;
  assign d_b0_o      = data_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed self-checking bench for bram_stream_loader.
// Covers LOADER_EARLY_LAST_EN both defined and undefined.
module tb_bram_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_load = 1'b0;
  logic [30:0] load_count = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  addr;
  logic        ce, we;
  logic [31:0] d;
  logic        start_run;
  logic [30:0] run_count;
  logic        acc_done = 1'b0;
  logic        idle, load, done;

  bram_stream_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start_load_i (start_load),
    .load_count_i (load_count),
    .s_valid_i    (s_valid),
    .s_data_i     (s_data),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready),
    .addr_b0_o    (addr),
    .ce_b0_o      (ce),
    .we_b0_o      (we),
    .d_b0_o       (d),
    .start_run_o  (start_run),
    .run_count_o  (run_count),
    .acc_done_i   (acc_done),
    .idle_o       (idle),
    .load_o       (load),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          n_run = 0;
  int          n_done = 0;
  int          n_split = 0;
  logic [30:0] run_seen = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ce && we) begin
        wa.push_back(addr);
        wd.push_back(d);
      end
      if (ce != we) n_split++;
      if (start_run) begin
        n_run++;
        run_seen = run_count;
      end
      if (done) n_done++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    n_run  = 0;
    n_done = 0;
  endtask

  task automatic start(int unsigned cnt);
    start_load = 1'b1;
    load_count = 31'(cnt);
    tick(1);
    start_load = 1'b0;
  endtask

  task automatic send(logic [7:0] b, logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    while (!s_ready && n < 20) begin
      tick(1);
      n++;
    end
    if (!s_ready) check("ready_timeout", 64'(s_ready), 64'd1);
    tick(1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_run();
    int d0 = n_done;
    tick(3);
    check("wait_holds", 64'(n_done), 64'(d0));
    acc_done = 1'b1;
    tick(1);
    acc_done = 1'b0;
    tick(2);
    check("done_pulse", 64'(n_done), 64'(d0 + 1));
    check("back_idle", 64'(idle), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int bad;
    tick(2);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_load", 64'(load), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_ce", 64'(ce), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_run", 64'(start_run), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_data", 64'(d), 64'd0);
    check("rst_rcnt", 64'(run_count), 64'd0);
    reset = 1'b0;
    tick(1);

    // two words, back-to-back bytes
    clr();
    start(2);
    check("t2_load", 64'(load), 64'd1);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    check("t2_ready_off", 64'(s_ready), 64'd0);
    check("t2_kick", 64'(start_run), 64'd1);
    tick(1);
    check("t2_kick_one", 64'(start_run), 64'd0);
    finish_run();
    check("t2_nwr", 64'(wa.size()), 64'd2);
    check("t2_a0", 64'(wa[0]), 64'd0);
    check("t2_d0", 64'(wd[0]), 64'h04030201);
    check("t2_a1", 64'(wa[1]), 64'd1);
    check("t2_d1", 64'(wd[1]), 64'h08070605);
    check("t2_nrun", 64'(n_run), 64'd1);
    check("t2_rcnt", 64'(run_seen), 64'd2);

    // oversize count clamps to the memory depth
    clr();
    start(300);
    for (int i = 0; i < 1024; i++) send(8'(i), 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    tick(3);
    check("t3_no_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    finish_run();
    check("t3_nwr", 64'(wa.size()), 64'd256);
    check("t3_a255", 64'(wa[255]), 64'd255);
    check("t3_d0", 64'(wd[0]), 64'h03020100);
    check("t3_d255", 64'(wd[255]), 64'hFFFEFDFC);
    bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] != 8'(i)) bad++;
      if (wd[i] != {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}) bad++;
    end
    check("t3_seq", 64'(bad), 64'd0);
    check("t3_rcnt", 64'(run_seen), 64'd256);
    check("t3_hold", 64'(run_count), 64'd256);

    // gapped stream, with a stray start mid-load
    clr();
    start(1);
    send(8'h11, 1'b0);
    tick(1);
    send(8'h22, 1'b0);
    start_load = 1'b1;
    load_count = 31'd5;
    tick(1);
    start_load = 1'b0;
    send(8'h33, 1'b0);
    tick(1);
    send(8'h44, 1'b0);
    finish_run();
    check("t4_nwr", 64'(wa.size()), 64'd1);
    check("t4_a0", 64'(wa[0]), 64'd0);
    check("t4_d0", 64'(wd[0]), 64'h44332211);
    check("t4_rcnt", 64'(run_seen), 64'd1);

    clr();
`ifdef LOADER_EARLY_LAST_EN
    start(4);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    check("t5_ready_off", 64'(s_ready), 64'd0);
    finish_run();
    check("t5_nwr", 64'(wa.size()), 64'd1);
    check("t5_a0", 64'(wa[0]), 64'd0);
    check("t5_d0", 64'(wd[0]), 64'h00CCBBAA);
    check("t5_rcnt", 64'(run_seen), 64'd1);
`else
    start(2);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    send(8'hDD, 1'b0);
    send(8'hEE, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    finish_run();
    check("t5_nwr", 64'(wa.size()), 64'd2);
    check("t5_d0", 64'(wd[0]), 64'hDDCCBBAA);
    check("t5_d1", 64'(wd[1]), 64'h2211FFEE);
    check("t5_rcnt", 64'(run_seen), 64'd2);
`endif

    // reset in the middle of the second word
    clr();
    start(2);
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    reset = 1'b1;
    tick(1);
    check("t6_idle", 64'(idle), 64'd1);
    check("t6_ready", 64'(s_ready), 64'd0);
    check("t6_ce", 64'(ce), 64'd0);
    check("t6_addr", 64'(addr), 64'd0);
    check("t6_data", 64'(d), 64'd0);
    check("t6_rcnt", 64'(run_count), 64'd0);
    reset = 1'b0;
    tick(2);
    check("t6_nwr", 64'(wa.size()), 64'd1);
    clr();
    start(2);
    for (int i = 9; i <= 16; i++) send(8'(i), 1'b0);
    finish_run();
    check("t6_re_nwr", 64'(wa.size()), 64'd2);
    check("t6_re_a0", 64'(wa[0]), 64'd0);
    check("t6_re_d0", 64'(wd[0]), 64'h0C0B0A09);
    check("t6_re_a1", 64'(wa[1]), 64'd1);

    // zero count goes straight to done
    clr();
    start(0);
    tick(3);
    check("t7_done", 64'(n_done), 64'd1);
    check("t7_nwr", 64'(wa.size()), 64'd0);
    check("t7_nrun", 64'(n_run), 64'd0);
    check("t7_idle", 64'(idle), 64'd1);

    check("ce_we_match", 64'(n_split), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
